riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
- Shares one main-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits at the core/memory boundary, below both caches' miss FSMs.
- Latches the winning request, holds it stable until memory acknowledges, then routes ready and read data back to the winner.
- Round-robin on contention; a watchdog flags a memory that never answers.

Parameters:
- DATA_WIDTH, 128, cache block / memory data width in bits.
- S_ADDR, 23, block address width (ADDR - BYTE_OFF).
- TIMEOUT, 1024, cycles a granted access may wait for i_riscv_memarb_mem_ready before the error flag sets; 0 disables the watchdog.
- TO_W, $clog2(TIMEOUT+1), watchdog counter width.

Ports:
- i_riscv_memarb_clk  in  1  clock, all state on rising edge.
- i_riscv_memarb_rst  in  1  asynchronous, active-low reset.
- i_riscv_memarb_i_rden  in  1  icache read request, level, held until its ready.
- i_riscv_memarb_i_addr  in  S_ADDR  icache block address.
- o_riscv_memarb_i_ready  out  1  icache access complete (1-cycle pulse).
- o_riscv_memarb_i_rdata  out  DATA_WIDTH  icache read data, valid with i_ready.
- i_riscv_memarb_d_rden  in  1  dcache read request, level.
- i_riscv_memarb_d_wren  in  1  dcache write-back request, level.
- i_riscv_memarb_d_addr  in  S_ADDR  dcache block address.
- i_riscv_memarb_d_wdata  in  DATA_WIDTH  dcache write-back data.
- o_riscv_memarb_d_ready  out  1  dcache access complete (1-cycle pulse).
- o_riscv_memarb_d_rdata  out  DATA_WIDTH  dcache read data, valid with d_ready.
- o_riscv_memarb_mem_rden  out  1  memory read strobe, level for whole access.
- o_riscv_memarb_mem_wren  out  1  memory write strobe, level for whole access.
- o_riscv_memarb_mem_addr  out  S_ADDR  latched block address.
- o_riscv_memarb_mem_wdata  out  DATA_WIDTH  latched write data.
- i_riscv_memarb_mem_ready  in  1  memory completion, 1-cycle pulse.
- i_riscv_memarb_mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready.
- o_riscv_memarb_owner  out  1  0 = icache, 1 = dcache; meaningful while strobes are active.
- o_riscv_memarb_timeout  out  1  sticky watchdog error.

Behaviour:
- FSM states:
  - IDLE: no strobe.
  - BUSY: strobe held, waiting for mem_ready.
  - RELEASE: one cycle in which the just-served requester's request is ignored while its FSM deasserts.
- Reset (rst=0, async): state=IDLE, all strobes/ready=0, addr/wdata=0, owner=0, last_grant=1 (dcache), watchdog counter=0, timeout=0.
- IDLE arbitration at a clock edge:
  - Only icache pending: grant icache.
  - Only dcache pending: grant dcache.
  - Both pending: grant the side that is not last_grant, so icache wins the first tie after reset.
- On grant: latch addr (and wdata for dcache), set owner, last_grant and the strobe. The strobe is visible the cycle after the request is first seen, so minimum request-to-strobe latency is 1 cycle.
- dcache with d_wren=1 and d_rden=1 together: write takes precedence; mem_wren=1, mem_rden=0.
- BUSY:
  - Strobes, addr and wdata stay constant regardless of input changes.
  - When mem_ready=1, the owner's ready is driven combinationally the same cycle and its rdata = mem_rdata. For writes, d_rdata is don't-care.
  - The other side's ready stays 0 and its rdata holds the last value.
  - Next edge: strobes drop, go to RELEASE.
- RELEASE:
  - Non-owner request pending: grant it directly, then BUSY.
  - Otherwise: IDLE.
  - Back-to-back accesses from the same requester therefore have at least one idle cycle between them.
- Watchdog:
  - Counter clears on grant and increments each BUSY cycle without mem_ready.
  - Reaching TIMEOUT sets timeout=1, which stays set until reset.
  - Arbitration is unaffected; the arbiter keeps waiting.
- mem_ready in IDLE or RELEASE: ignored, no ready forwarded.
- Async reset mid-access: immediate return to the reset state with strobes low. The memory side must tolerate the aborted access.

Test Plan:
- icache alone: i_rden=1, i_addr=0x000010; mem_ready at 3rd BUSY cycle with rdata=0xA5..A5 -> mem_rden=1, addr=0x000010 for 3 cycles; i_ready pulses 1 cycle with rdata=0xA5..A5; d_ready=0.
- Simultaneous after reset: i_rden and d_rden rise together -> icache served first, dcache granted out of RELEASE; owner sequence 0 then 1; no idle gap between the accesses.
- Tie rotation: both requesters held continuously over 4 accesses -> owners 0,1,0,1.
- Dcache write-back: d_wren=1, d_wdata=0x0123..CDEF, addr=0x7FFFFF -> mem_wren=1, mem_rden=0; wdata/addr stable while d_wdata is changed mid-BUSY.
- Watchdog: TIMEOUT=8, mem_ready never arrives -> timeout=1 after the 8th BUSY cycle and stays 1. A late mem_ready then completes the access normally. Reset clears timeout.
- Reset mid-BUSY: rst=0 while mem_rden=1 -> mem_rden=0 immediately, before the next clock edge. After release, a new request is granted normally.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one main-memory port between the instruction cache
// (read-only) and the data cache (read/write). The winning request is latched and
// held until memory acknowledges, then ready and read data are routed back to the
// winner. Ties alternate between the two sides, and a sticky watchdog flag reports
// a memory that never answers.
module riscv_mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned S_ADDR     = 23,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned TO_W       = $clog2(TIMEOUT + 1)
) (
    input  logic                  i_riscv_memarb_clk,
    input  logic                  i_riscv_memarb_rst,

    // Instruction cache side
    input  logic                  i_riscv_memarb_i_rden,
    input  logic [S_ADDR-1:0]     i_riscv_memarb_i_addr,
    output logic                  o_riscv_memarb_i_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_i_rdata,

    // Data cache side
    input  logic                  i_riscv_memarb_d_rden,
    input  logic                  i_riscv_memarb_d_wren,
    input  logic [S_ADDR-1:0]     i_riscv_memarb_d_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_memarb_d_wdata,
    output logic                  o_riscv_memarb_d_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_d_rdata,

    // Memory side
    output logic                  o_riscv_memarb_mem_rden,
    output logic                  o_riscv_memarb_mem_wren,
    output logic [S_ADDR-1:0]     o_riscv_memarb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_mem_wdata,
    input  logic                  i_riscv_memarb_mem_ready,
    input  logic [DATA_WIDTH-1:0] i_riscv_memarb_mem_rdata,

    // Status
    output logic                  o_riscv_memarb_owner,
    output logic                  o_riscv_memarb_timeout
);

    // A zero TIMEOUT gives a zero-width counter; keep at least one bit so the
    // register stays legal even though it is never used in that case.
    localparam int unsigned     CNT_W    = (TO_W < 1) ? 1 : TO_W;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam bit              WD_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusy    = 2'd1,
        StRelease = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    mem_rden_q;
    logic                    mem_wren_q;
    logic [S_ADDR-1:0]       addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    owner_q;
    logic                    last_grant_q;
    logic [CNT_W-1:0]        wd_cnt_q;
    logic                    timeout_q;
    logic [DATA_WIDTH-1:0]   i_rdata_q;
    logic [DATA_WIDTH-1:0]   d_rdata_q;

    logic                    i_pend;
    logic                    d_pend;
    logic                    grant_valid;
    logic                    grant_dcache;
    logic                    serve_done;
    logic [CNT_W-1:0]        wd_cnt_inc;

    // Pick the winner for the coming edge; only meaningful in IDLE and RELEASE.
    always_comb begin
        i_pend       = i_riscv_memarb_i_rden;
        d_pend       = i_riscv_memarb_d_rden | i_riscv_memarb_d_wren;
        grant_valid  = 1'b0;
        grant_dcache = 1'b0;
        case (state_q)
            StIdle: begin
                grant_valid  = i_pend | d_pend;
                // On a tie the side that did not win last time goes first.
                grant_dcache = d_pend & (~i_pend | ~last_grant_q);
            end
            StRelease: begin
                // The side just served is still withdrawing its request, so only
                // the other side can be granted in this cycle.
                if (owner_q) begin
                    grant_valid  = i_pend;
                    grant_dcache = 1'b0;
                end else begin
                    grant_valid  = d_pend;
                    grant_dcache = 1'b1;
                end
            end
            default: begin
                grant_valid  = 1'b0;
                grant_dcache = 1'b0;
            end
        endcase
    end

    // Completion strobe and saturating watchdog increment.
    always_comb begin
        serve_done = (state_q == StBusy) & i_riscv_memarb_mem_ready;
        wd_cnt_inc = wd_cnt_q + CNT_W'(1);
    end

    // Arbitration FSM with registered memory strobes, latched request and watchdog.
    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst) begin
        if (!i_riscv_memarb_rst) begin
            state_q      <= StIdle;
            mem_rden_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state_q)
                StIdle, StRelease: begin
                    if (grant_valid) begin
                        state_q      <= StBusy;
                        owner_q      <= grant_dcache;
                        last_grant_q <= grant_dcache;
                        wd_cnt_q     <= '0;
                        if (grant_dcache) begin
                            addr_q     <= i_riscv_memarb_d_addr;
                            wdata_q    <= i_riscv_memarb_d_wdata;
                            // A write-back wins over a simultaneous read request.
                            mem_wren_q <= i_riscv_memarb_d_wren;
                            mem_rden_q <= ~i_riscv_memarb_d_wren;
                        end else begin
                            addr_q     <= i_riscv_memarb_i_addr;
                            mem_rden_q <= 1'b1;
                            mem_wren_q <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBusy: begin
                    if (i_riscv_memarb_mem_ready) begin
                        state_q    <= StRelease;
                        mem_rden_q <= 1'b0;
                        mem_wren_q <= 1'b0;
                        if (owner_q) begin
                            d_rdata_q <= i_riscv_memarb_mem_rdata;
                        end else begin
                            i_rdata_q <= i_riscv_memarb_mem_rdata;
                        end
                    end else if (WD_EN) begin
                        if (wd_cnt_q != TO_LIMIT) begin
                            wd_cnt_q <= wd_cnt_inc;
                        end
                        if (wd_cnt_inc == TO_LIMIT) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    mem_rden_q <= 1'b0;
                    mem_wren_q <= 1'b0;
                end
            endcase
        end
    end

    // Route completion back to the owner; the other side keeps its last data.
    always_comb begin
        o_riscv_memarb_i_ready = serve_done & ~owner_q;
        o_riscv_memarb_d_ready = serve_done & owner_q;
        o_riscv_memarb_i_rdata = o_riscv_memarb_i_ready ? i_riscv_memarb_mem_rdata : i_rdata_q;
        o_riscv_memarb_d_rdata = o_riscv_memarb_d_ready ? i_riscv_memarb_mem_rdata : d_rdata_q;
    end

    assign o_riscv_memarb_mem_rden  = mem_rden_q;
    assign o_riscv_memarb_mem_wren  = mem_wren_q;
    assign o_riscv_memarb_mem_addr  = addr_q;
    assign o_riscv_memarb_mem_wdata = wdata_q;
    assign o_riscv_memarb_owner     = owner_q;
    assign o_riscv_memarb_timeout   = timeout_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: a transaction-level model checked every falling
// edge, plus directed scenarios with literal expectations.
module tb_riscv_mem_arbiter;

    localparam int DW = 128;
    localparam int AW = 23;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_rden = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_rden = 1'b0;
    logic          d_wren = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_rden;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          owner;
    logic          timeout;

    riscv_mem_arbiter #(
        .DATA_WIDTH(DW),
        .S_ADDR    (AW),
        .TIMEOUT   (TO)
    ) dut (
        .i_riscv_memarb_clk      (clk),
        .i_riscv_memarb_rst      (rst_n),
        .i_riscv_memarb_i_rden   (i_rden),
        .i_riscv_memarb_i_addr   (i_addr),
        .o_riscv_memarb_i_ready  (i_ready),
        .o_riscv_memarb_i_rdata  (i_rdata),
        .i_riscv_memarb_d_rden   (d_rden),
        .i_riscv_memarb_d_wren   (d_wren),
        .i_riscv_memarb_d_addr   (d_addr),
        .i_riscv_memarb_d_wdata  (d_wdata),
        .o_riscv_memarb_d_ready  (d_ready),
        .o_riscv_memarb_d_rdata  (d_rdata),
        .o_riscv_memarb_mem_rden (mem_rden),
        .o_riscv_memarb_mem_wren (mem_wren),
        .o_riscv_memarb_mem_addr (mem_addr),
        .o_riscv_memarb_mem_wdata(mem_wdata),
        .i_riscv_memarb_mem_ready(mem_ready),
        .i_riscv_memarb_mem_rdata(mem_rdata),
        .o_riscv_memarb_owner    (owner),
        .o_riscv_memarb_timeout  (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one access record, the requester to ignore for one
    // cycle after completion, last winner, wait count and sticky error.
    bit            m_active, m_who, m_write, m_skip_v, m_skip_who, m_last, m_to, m_dknown;
    int            m_wait;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_ihold, m_dhold;
    bit            ireq, dreq, winner;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_who = 0; m_write = 0; m_skip_v = 0; m_skip_who = 0;
            m_last = 1; m_to = 0; m_dknown = 1; m_wait = 0;
            m_addr = '0; m_wdata = '0; m_ihold = '0; m_dhold = '0;
        end else if (m_active) begin
            if (mem_ready) begin
                if (m_who) begin
                    m_dhold  = mem_rdata;
                    m_dknown = !m_write;
                end else begin
                    m_ihold = mem_rdata;
                end
                m_active   = 0;
                m_skip_v   = 1;
                m_skip_who = m_who;
            end else begin
                m_wait++;
                if (m_wait >= TO) m_to = 1;
            end
        end else begin
            ireq = i_rden && !(m_skip_v && m_skip_who == 0);
            dreq = (d_rden || d_wren) && !(m_skip_v && m_skip_who == 1);
            if (ireq || dreq) begin
                winner   = (ireq && dreq) ? !m_last : dreq;
                m_active = 1;
                m_who    = winner;
                m_last   = winner;
                m_wait   = 0;
                if (winner) begin
                    m_write = d_wren;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                end else begin
                    m_write = 0;
                    m_addr  = i_addr;
                end
            end
            m_skip_v = 0;
        end
    end

    // Every falling edge: compare DUT outputs against the model.
    always @(negedge clk) begin
        bit e_ir, e_dr;
        e_ir = m_active && !m_who && mem_ready;
        e_dr = m_active && m_who && mem_ready;
        check("m.mem_rden", mem_rden, m_active && !m_write);
        check("m.mem_wren", mem_wren, m_active && m_write);
        check("m.mem_addr", mem_addr, m_addr);
        check("m.mem_wdata", mem_wdata, m_wdata);
        check("m.timeout", timeout, m_to);
        check("m.i_ready", i_ready, e_ir);
        check("m.d_ready", d_ready, e_dr);
        check("m.i_rdata", i_rdata, e_ir ? mem_rdata : m_ihold);
        if (m_active) check("m.owner", owner, m_who);
        if (e_dr && !m_write) check("m.d_rdata", d_rdata, mem_rdata);
        else if (!e_dr && m_dknown) check("m.d_rdata", d_rdata, m_dhold);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic [DW-1:0] pat_a5, pat_1, pat_2, pat_wd, pat_dead;
    int            exp_own[4] = '{0, 1, 0, 1};

    initial begin
        pat_a5   = {16{8'hA5}};
        pat_1    = {4{32'h1111_0001}};
        pat_2    = {4{32'h2222_0002}};
        pat_wd   = {2{64'h0123_4567_89AB_CDEF}};
        pat_dead = {4{32'hDEAD_BEEF}};

        // Reset state
        step();
        #1;
        check("rst.mem_rden", mem_rden, 0);
        check("rst.mem_wren", mem_wren, 0);
        check("rst.owner", owner, 0);
        check("rst.addr", mem_addr, 0);
        check("rst.timeout", timeout, 0);
        rst_n = 1'b1;
        step();

        // icache alone, ready on the third BUSY cycle
        i_rden = 1'b1;
        i_addr = 23'h000010;
        for (int c = 1; c <= 3; c++) begin
            step();
            #1;
            check("ic.mem_rden", mem_rden, 1);
            check("ic.addr", mem_addr, 23'h000010);
        end
        mem_ready = 1'b1;
        mem_rdata = pat_a5;
        #1;
        check("ic.i_ready", i_ready, 1);
        check("ic.i_rdata", i_rdata, pat_a5);
        check("ic.d_ready", d_ready, 0);
        step();
        mem_ready = 1'b0;
        i_rden    = 1'b0;
        #1;
        check("ic.release_rden", mem_rden, 0);
        check("ic.ready_pulse", i_ready, 0);
        step();

        // Stray mem_ready while idle is ignored
        mem_ready = 1'b1;
        #1;
        check("idle.i_ready", i_ready, 0);
        check("idle.d_ready", d_ready, 0);
        step();
        mem_ready = 1'b0;

        // Simultaneous requests after reset: icache first, then dcache out of RELEASE
        reset_pulse();
        i_rden = 1'b1; i_addr = 23'h000100;
        d_rden = 1'b1; d_addr = 23'h000200;
        step();
        #1;
        check("sim.owner0", owner, 0);
        check("sim.addr0", mem_addr, 23'h000100);
        mem_ready = 1'b1; mem_rdata = pat_1;
        #1;
        check("sim.i_ready", i_ready, 1);
        step();
        mem_ready = 1'b0; i_rden = 1'b0;
        step();
        #1;
        check("sim.owner1", owner, 1);
        check("sim.d_strobe", mem_rden, 1);
        check("sim.addr1", mem_addr, 23'h000200);
        mem_ready = 1'b1; mem_rdata = pat_2;
        #1;
        check("sim.d_ready", d_ready, 1);
        check("sim.d_rdata", d_rdata, pat_2);
        check("sim.i_hold", i_rdata, pat_1);
        step();
        mem_ready = 1'b0; d_rden = 1'b0;
        step();

        // Both held continuously: owners alternate 0,1,0,1
        i_rden = 1'b1; d_rden = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            check("rot.owner", owner, exp_own[k]);
            mem_ready = 1'b1; mem_rdata = DW'(k + 7);
            step();
            mem_ready = 1'b0;
            if (k == 3) begin i_rden = 1'b0; d_rden = 1'b0; end
            #1;
            check("rot.gap", mem_rden, 0);
        end
        step();

        // dcache write-back with read also asserted; latched values stay put
        d_wren = 1'b1; d_rden = 1'b1; d_addr = 23'h7FFFFF; d_wdata = pat_wd;
        step();
        #1;
        check("wb.mem_wren", mem_wren, 1);
        check("wb.mem_rden", mem_rden, 0);
        check("wb.addr", mem_addr, 23'h7FFFFF);
        d_wdata = '0; d_addr = '0;
        step();
        #1;
        check("wb.wdata_hold", mem_wdata, pat_wd);
        check("wb.addr_hold", mem_addr, 23'h7FFFFF);
        mem_ready = 1'b1; mem_rdata = '0;
        #1;
        check("wb.d_ready", d_ready, 1);
        step();
        mem_ready = 1'b0; d_wren = 1'b0; d_rden = 1'b0;
        step();

        // Watchdog: no answer for 8 BUSY cycles, then a late answer
        i_rden = 1'b1; i_addr = 23'h000055;
        for (int n = 1; n <= TO; n++) begin
            step();
            #1;
            check("wd.before", timeout, 0);
        end
        step();
        #1;
        check("wd.set", timeout, 1);
        step(); step();
        #1;
        check("wd.sticky", timeout, 1);
        check("wd.waiting", mem_rden, 1);
        mem_ready = 1'b1; mem_rdata = pat_dead;
        #1;
        check("wd.late_ready", i_ready, 1);
        check("wd.late_rdata", i_rdata, pat_dead);
        step();
        mem_ready = 1'b0; i_rden = 1'b0;
        step();
        #1;
        check("wd.after", timeout, 1);
        reset_pulse();
        #1;
        check("wd.cleared", timeout, 0);

        // Reset in the middle of an access drops the strobe without a clock
        d_rden = 1'b1; d_addr = 23'h000333;
        step();
        #1;
        check("rb.strobe", mem_rden, 1);
        rst_n = 1'b0;
        #1;
        check("rb.async", mem_rden, 0);
        step();
        d_rden = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        i_rden = 1'b1; i_addr = 23'h000444;
        step();
        #1;
        check("rb.regrant", mem_rden, 1);
        check("rb.owner", owner, 0);
        check("rb.addr", mem_addr, 23'h000444);
        mem_ready = 1'b1; mem_rdata = pat_1;
        step();
        mem_ready = 1'b0; i_rden = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
